// File: rtl/card_pkg.sv
// ============================================================================
// Module      : card_pkg
// Description : Shared widths, state/winner encodings and card validity check
//               for the two-player card game.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package card_pkg;

    localparam int COLOR_W = 2;
    localparam int NUM_W   = 3;
    localparam int SCORE_W = 6;
    localparam int COUNT_W = 4;
    localparam int NUM_MAX = 4;

    typedef enum logic [1:0] {
        PLAY = 2'd0,
        EVAL = 2'd1,
        OVER = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        P0   = 2'b01,
        P1   = 2'b10,
        TIE  = 2'b11
    } winner_t;

    // A card is playable when it has a real color and a number in 0..4.
    function automatic logic card_valid(input logic [COLOR_W-1:0] color,
                                        input logic [NUM_W-1:0]   number);
        return (color != '0) && (number <= NUM_W'(NUM_MAX));
    endfunction

endpackage

`default_nettype wire

// File: rtl/player_hand.sv
// ============================================================================
// Module      : player_hand
// Description : One player's score, card count, color streak and last color.
//               Also exposes the score the pending update would produce so
//               the judge can decide on the same edge the score lands.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module player_hand
    import card_pkg::*;
#(
    parameter int HAND_MAX = 8,
    parameter int BONUS    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               update,
    input  logic [COLOR_W-1:0] color,
    input  logic [NUM_W-1:0]   number,
    input  logic               clear,
    output logic [SCORE_W-1:0] score,
    output logic [COUNT_W-1:0] count,
    output logic               full,
    output logic [SCORE_W-1:0] score_next
);

    localparam logic [COUNT_W-1:0] c_hand_max = COUNT_W'(HAND_MAX);
    localparam logic [SCORE_W-1:0] c_bonus    = SCORE_W'(BONUS);

    logic [SCORE_W-1:0] r_score;
    logic [COUNT_W-1:0] r_count;
    logic [1:0]         r_streak;
    logic [COLOR_W-1:0] r_last_color;

    logic [1:0]         w_streak_inc;
    logic               w_bonus;
    logic [1:0]         w_streak_next;

    // Streak advance and bonus: the third same-color card in a row scores
    // the bonus and restarts the streak from zero.
    always_comb begin
        w_streak_inc  = (color == r_last_color) ? (r_streak + 2'd1) : 2'd1;
        w_bonus       = (w_streak_inc == 2'd3);
        w_streak_next = w_bonus ? 2'd0 : w_streak_inc;
        score_next    = r_score + SCORE_W'(number) + SCORE_W'(1)
                        + (w_bonus ? c_bonus : '0);
    end

    // Hand state registers; clear has priority over a pending update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_score      <= '0;
            r_count      <= '0;
            r_streak     <= '0;
            r_last_color <= '0;
        end else if (clear) begin
            r_score      <= '0;
            r_count      <= '0;
            r_streak     <= '0;
            r_last_color <= '0;
        end else if (update) begin
            r_score      <= score_next;
            r_count      <= r_count + COUNT_W'(1);
            r_streak     <= w_streak_next;
            r_last_color <= color;
        end
    end

    assign score = r_score;
    assign count = r_count;
    assign full  = (r_count == c_hand_max);

endmodule

`default_nettype wire

// File: rtl/score_judge.sv
// ============================================================================
// Module      : score_judge
// Description : Captures dealt cards for the active player, updates that
//               player's hand for one EVAL cycle, judges exact-target, bust
//               and full-hands outcomes, and holds the result until restart.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module score_judge
    import card_pkg::*;
#(
    parameter int TARGET   = 21,
    parameter int HAND_MAX = 8,
    parameter int BONUS    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               deal,
    input  logic               whose,
    input  logic [COLOR_W-1:0] color,
    input  logic [NUM_W-1:0]   number,
    input  logic               restart,
    output logic [SCORE_W-1:0] score0,
    output logic [SCORE_W-1:0] score1,
    output logic [COUNT_W-1:0] count0,
    output logic [COUNT_W-1:0] count1,
    output logic               busy,
    output logic               game_over,
    output logic [1:0]         winner,
    output logic               drop
);

    localparam logic [SCORE_W-1:0] c_target   = SCORE_W'(TARGET);
    localparam logic [COUNT_W-1:0] c_hand_max = COUNT_W'(HAND_MAX);

    state_t             r_state;
    state_t             w_state_next;
    logic               r_cap_whose;
    logic [COLOR_W-1:0] r_cap_color;
    logic [NUM_W-1:0]   r_cap_number;
    logic               r_drop;
    winner_t            r_winner;

    logic               w_capture;
    logic               w_drop_set;
    logic               w_upd0;
    logic               w_upd1;
    logic               w_win_load;
    winner_t            w_winner_next;

    logic [SCORE_W-1:0] w_score0;
    logic [SCORE_W-1:0] w_score1;
    logic [SCORE_W-1:0] w_score_next0;
    logic [SCORE_W-1:0] w_score_next1;
    logic [COUNT_W-1:0] w_count0;
    logic [COUNT_W-1:0] w_count1;
    logic               w_full0;
    logic               w_full1;

    logic [SCORE_W-1:0] w_cap_score_new;
    logic [SCORE_W-1:0] w_s0_after;
    logic [SCORE_W-1:0] w_s1_after;
    logic [COUNT_W-1:0] w_c0_after;
    logic [COUNT_W-1:0] w_c1_after;

    player_hand #(
        .HAND_MAX (HAND_MAX),
        .BONUS    (BONUS)
    ) u_hand0 (
        .clk        (clk),
        .rst        (rst),
        .update     (w_upd0),
        .color      (r_cap_color),
        .number     (r_cap_number),
        .clear      (restart),
        .score      (w_score0),
        .count      (w_count0),
        .full       (w_full0),
        .score_next (w_score_next0)
    );

    player_hand #(
        .HAND_MAX (HAND_MAX),
        .BONUS    (BONUS)
    ) u_hand1 (
        .clk        (clk),
        .rst        (rst),
        .update     (w_upd1),
        .color      (r_cap_color),
        .number     (r_cap_number),
        .clear      (restart),
        .score      (w_score1),
        .count      (w_count1),
        .full       (w_full1),
        .score_next (w_score_next1)
    );

    // Post-update view of both hands, as it will look after the EVAL edge.
    always_comb begin
        w_cap_score_new = r_cap_whose ? w_score_next1 : w_score_next0;
        w_s0_after      = r_cap_whose ? w_score0 : w_score_next0;
        w_s1_after      = r_cap_whose ? w_score_next1 : w_score1;
        w_c0_after      = r_cap_whose ? w_count0 : (w_count0 + COUNT_W'(1));
        w_c1_after      = r_cap_whose ? (w_count1 + COUNT_W'(1)) : w_count1;
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= PLAY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, capture/update strobes, drop requests and judging.
    always_comb begin
        w_state_next  = r_state;
        w_capture     = 1'b0;
        w_drop_set    = 1'b0;
        w_upd0        = 1'b0;
        w_upd1        = 1'b0;
        w_win_load    = 1'b0;
        w_winner_next = NONE;

        case (r_state)
            PLAY: begin
                if (deal && !restart) begin
                    if (card_valid(color, number) && !(whose ? w_full1 : w_full0)) begin
                        w_capture    = 1'b1;
                        w_state_next = EVAL;
                    end else begin
                        w_drop_set = 1'b1;
                    end
                end
            end
            EVAL: begin
                if (!restart) begin
                    w_upd0     = !r_cap_whose;
                    w_upd1     = r_cap_whose;
                    w_drop_set = deal;
                    if (w_cap_score_new == c_target) begin
                        w_winner_next = r_cap_whose ? P1 : P0;
                    end else if (w_cap_score_new > c_target) begin
                        w_winner_next = r_cap_whose ? P0 : P1;
                    end else if ((w_c0_after == c_hand_max) && (w_c1_after == c_hand_max)) begin
                        if (w_s0_after > w_s1_after) begin
                            w_winner_next = P0;
                        end else if (w_s0_after < w_s1_after) begin
                            w_winner_next = P1;
                        end else begin
                            w_winner_next = TIE;
                        end
                    end
                    w_win_load   = (w_winner_next != NONE);
                    w_state_next = w_win_load ? OVER : PLAY;
                end
            end
            OVER: begin
                w_drop_set = deal && !restart;
            end
            default: begin
                w_state_next = PLAY;
            end
        endcase

        if (restart) begin
            w_state_next = PLAY;
        end
    end

    // Capture registers for the card being evaluated.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cap_whose  <= 1'b0;
            r_cap_color  <= '0;
            r_cap_number <= '0;
        end else if (w_capture) begin
            r_cap_whose  <= whose;
            r_cap_color  <= color;
            r_cap_number <= number;
        end
    end

    // Sticky drop flag and held winner; both cleared by restart.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_drop   <= 1'b0;
            r_winner <= NONE;
        end else if (restart) begin
            r_drop   <= 1'b0;
            r_winner <= NONE;
        end else begin
            if (w_drop_set) begin
                r_drop <= 1'b1;
            end
            if (w_win_load) begin
                r_winner <= w_winner_next;
            end
        end
    end

    assign score0    = w_score0;
    assign score1    = w_score1;
    assign count0    = w_count0;
    assign count1    = w_count1;
    assign busy      = (r_state == EVAL);
    assign game_over = (r_state == OVER);
    assign winner    = r_winner;
    assign drop      = r_drop;

endmodule

`default_nettype wire

// File: tb/tb_score_judge.sv
// ============================================================================
// Module      : tb_score_judge
// Description : Scoreboard bench for score_judge. A behavioural game model
//               pushes expected outputs per deal; they are popped and compared
//               once the DUT has produced its result.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_score_judge;

    localparam int TARGET   = 21;
    localparam int HAND_MAX = 8;
    localparam int BONUS    = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       deal;
    logic       whose;
    logic [1:0] color;
    logic [2:0] number;
    logic       restart;
    logic [5:0] score0;
    logic [5:0] score1;
    logic [3:0] count0;
    logic [3:0] count1;
    logic       busy;
    logic       game_over;
    logic [1:0] winner;
    logic       drop;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int s0;
        int s1;
        int c0;
        int c1;
        int win;
        int go;
        int drp;
    } exp_t;

    exp_t q[$];

    int m_score  [2];
    int m_count  [2];
    int m_streak [2];
    int m_last   [2];
    int m_win;
    int m_drop;
    bit m_over;

    score_judge #(
        .TARGET   (TARGET),
        .HAND_MAX (HAND_MAX),
        .BONUS    (BONUS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .deal      (deal),
        .whose     (whose),
        .color     (color),
        .number    (number),
        .restart   (restart),
        .score0    (score0),
        .score1    (score1),
        .count0    (count0),
        .count1    (count1),
        .busy      (busy),
        .game_over (game_over),
        .winner    (winner),
        .drop      (drop)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_score[i]  = 0;
            m_count[i]  = 0;
            m_streak[i] = 0;
            m_last[i]   = 0;
        end
        m_win  = 0;
        m_drop = 0;
        m_over = 1'b0;
    endfunction

    // Game model: returns 1 when the deal is accepted into EVAL.
    function automatic bit model_deal(input int w, input int c, input int n);
        if (m_over || c == 0 || n > 4 || m_count[w] >= HAND_MAX) begin
            m_drop = 1;
            return 1'b0;
        end
        m_score[w] += n + 1;
        m_count[w] += 1;
        m_streak[w] = (c == m_last[w]) ? m_streak[w] + 1 : 1;
        m_last[w]   = c;
        if (m_streak[w] == 3) begin
            m_score[w] += BONUS;
            m_streak[w] = 0;
        end
        if (m_score[w] == TARGET)
            m_win = (w == 1) ? 2 : 1;
        else if (m_score[w] > TARGET)
            m_win = (w == 1) ? 1 : 2;
        else if (m_count[0] == HAND_MAX && m_count[1] == HAND_MAX)
            m_win = (m_score[0] > m_score[1]) ? 1 : (m_score[0] < m_score[1]) ? 2 : 3;
        if (m_win != 0)
            m_over = 1'b1;
        return 1'b1;
    endfunction

    task automatic push_expected();
        exp_t e;
        e.s0  = m_score[0];
        e.s1  = m_score[1];
        e.c0  = m_count[0];
        e.c1  = m_count[1];
        e.win = m_win;
        e.go  = int'(m_over);
        e.drp = m_drop;
        q.push_back(e);
    endtask

    task automatic compare_outputs(input string tag);
        exp_t e;
        check_value({tag, ":qdepth"}, q.size(), 1);
        if (q.size() != 0) begin
            e = q.pop_front();
            check_value({tag, ":score0"},    score0,    e.s0);
            check_value({tag, ":score1"},    score1,    e.s1);
            check_value({tag, ":count0"},    count0,    e.c0);
            check_value({tag, ":count1"},    count1,    e.c1);
            check_value({tag, ":winner"},    winner,    e.win);
            check_value({tag, ":game_over"}, game_over, e.go);
            check_value({tag, ":drop"},      drop,      e.drp);
        end
    endtask

    // Drive one deal at a falling edge; the result is checked one falling
    // edge after the update edge (two edges for accepted cards).
    task automatic do_deal(input string tag, input int w, input int c, input int n);
        bit acc;
        acc = model_deal(w, c, n);
        push_expected();
        @(negedge clk);
        deal   = 1'b1;
        whose  = w[0];
        color  = c[1:0];
        number = n[2:0];
        @(negedge clk);
        deal = 1'b0;
        check_value({tag, ":busy"}, busy, acc);
        if (acc) begin
            @(negedge clk);
            check_value({tag, ":busy_end"}, busy, 0);
        end
        compare_outputs(tag);
    endtask

    task automatic do_restart(input string tag, input bit with_deal);
        @(negedge clk);
        restart = 1'b1;
        deal    = with_deal;
        whose   = 1'b0;
        color   = 2'd1;
        number  = 3'd4;
        @(negedge clk);
        restart = 1'b0;
        deal    = 1'b0;
        model_reset();
        push_expected();
        check_value({tag, ":busy"}, busy, 0);
        compare_outputs(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst     = 1'b0;
        deal    = 1'b0;
        whose   = 1'b0;
        color   = 2'd0;
        number  = 3'd0;
        restart = 1'b0;
        model_reset();
        #12;
        push_expected();
        check_value("reset:busy", busy, 0);
        compare_outputs("reset");
        @(negedge clk);
        rst = 1'b1;

        // Basic deal: 4 -> +5.
        do_deal("first", 0, 2, 4);

        // Three same-color cards to player0: 1, 2, then 6 with bonus.
        do_restart("rs1", 1'b0);
        for (int i = 0; i < 3; i++) do_deal($sformatf("streak%0d", i), 0, 1, 0);
        do_deal("p1_unaffected", 1, 1, 0);

        // Player1 to 18 then exact 21.
        do_restart("rs2", 1'b0);
        do_deal("p1a", 1, 1, 4);
        do_deal("p1b", 1, 2, 4);
        do_deal("p1c", 1, 1, 4);
        do_deal("p1d", 1, 2, 2);
        do_deal("p1_exact", 1, 1, 2);
        do_deal("over_drop", 0, 1, 1);

        // Player0 to 19 then bust.
        do_restart("rs3", 1'b0);
        do_deal("p0a", 0, 1, 4);
        do_deal("p0b", 0, 2, 4);
        do_deal("p0c", 0, 1, 4);
        do_deal("p0d", 0, 2, 3);
        do_deal("p0_bust", 0, 1, 4);

        // Invalid cards, then restart colliding with a valid deal.
        do_restart("rs4", 1'b0);
        do_deal("bad_color", 0, 0, 1);
        do_deal("bad_number", 1, 2, 6);
        do_restart("rs_with_deal", 1'b1);

        // Equal full hands -> tie.
        for (int i = 0; i < HAND_MAX; i++) begin
            do_deal($sformatf("tie0_%0d", i), 0, (i % 2) + 1, 0);
            do_deal($sformatf("tie1_%0d", i), 1, (i % 2) + 1, 0);
        end

        // Unequal full hands; ninth card to a full hand is dropped in PLAY.
        do_restart("rs5", 1'b0);
        for (int i = 0; i < HAND_MAX; i++)
            do_deal($sformatf("full0_%0d", i), 0, (i % 2) + 1, 0);
        for (int i = 0; i < HAND_MAX - 1; i++)
            do_deal($sformatf("full1_%0d", i), 1, (i % 2) + 1, 1);
        do_deal("ninth", 0, 1, 0);
        do_deal("last_p1", 1, 2, 0);

        // Asynchronous reset while EVAL is in progress.
        do_restart("rs6", 1'b0);
        do_deal("pre_rst", 1, 3, 3);
        @(negedge clk);
        deal   = 1'b1;
        whose  = 1'b0;
        color  = 2'd2;
        number = 3'd2;
        @(posedge clk);
        #1;
        deal = 1'b0;
        check_value("mid_eval:busy", busy, 1);
        rst = 1'b0;
        #1;
        model_reset();
        push_expected();
        check_value("async_rst:busy", busy, 0);
        compare_outputs("async_rst");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        push_expected();
        compare_outputs("after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/score_judge.md
# score_judge

Downstream consumer of the card generator and turn tracker in the two-player card game. On each deal pulse it captures the current card (color, number) for the player whose turn it is and updates that player's hand count, color streak and running score. It declares a winner on exact target, bust or both hands full, and holds the result until restart. Its outputs drive the score display and the game-over indicator.

## Interface
Parameters:
- TARGET, 21: exact score that wins; a score above it busts.
- HAND_MAX, 8: cards per player hand; a further deal to that player is dropped.
- BONUS, 3: points added when a player's third consecutive same-color card lands.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-low reset; clears every register immediately.
- deal  in  1  one-cycle pulse; request to take the current card.
- whose  in  1  player receiving the card: 0 = player0, 1 = player1.
- color  in  2  card color; 1..3 valid, 0 invalid.
- number  in  3  card number; 0..4 valid, 5..7 invalid.
- restart  in  1  one-cycle pulse; clears the game state (see Operation).
- score0, score1  out  6  running scores.
- count0, count1  out  4  cards held by each player.
- busy  out  1  high during the EVAL cycle.
- game_over  out  1  high in state OVER.
- winner  out  2  00 none, 01 player0, 10 player1, 11 tie.
- drop  out  1  sticky flag; set by any ignored deal, cleared by restart or reset.

## Operation
State machine with three states:
- PLAY:
  - On a deal with a valid card and the target hand not full: latch whose, color and number into capture registers, then go to EVAL.
  - On a deal with an invalid card or a full target hand: set drop, stay in PLAY.
- EVAL (exactly one cycle), for the captured player:
  - score += number + 1.
  - count += 1.
  - Streak: if color equals that player's last color, streak += 1; otherwise streak = 1. When streak reaches 3, add BONUS to the score and reset streak to 0.
  - Judging, in priority order:
    - new score == TARGET: that player wins.
    - new score > TARGET: the other player wins.
    - both counts == HAND_MAX: the higher score wins; equal scores give winner = 11.
  - Any judge outcome goes to OVER; otherwise return to PLAY.
- OVER:
  - Outputs are frozen.
  - A deal sets drop.
  - restart goes to PLAY.
- restart from any state:
  - Clears scores, counts, streaks, last colors, winner and drop, and enters PLAY.
  - restart wins over a simultaneous deal; that deal is discarded and does not set drop.
- Deal during EVAL: ignored, drop set.
- Width rules: scores never wrap. The prior score is at most TARGET and each step adds at most 5 + BONUS, so the maximum is 29, which fits 6 bits.

## Timing
- Reset values: score0 = score1 = 0, count0 = count1 = 0, busy = 0, game_over = 0, winner = 00, drop = 0, state PLAY, streaks 0, last colors 0.
- Deal sampled at edge N: capture occurs at edge N, busy is high from N to N+1, and scores, counts, winner and game_over update at edge N+1.
- Deal-to-result latency is 2 edges. A new deal is accepted at edge N+2 at the earliest.
- restart takes effect at the edge that samples it.
- Reset asserted mid-EVAL: the capture is lost and all outputs return to reset values at once, independent of clk.

## Structure
- Shared package card_pkg holds:
  - COLOR_W = 2, NUM_W = 3, SCORE_W = 6.
  - State encoding PLAY/EVAL/OVER.
  - Winner codes NONE/P0/P1/TIE.
  - A valid-card check function: color != 0 and number <= 4.
- Sub-module player_hand, instantiated twice, holds one player's score, count, streak and last color. Its ports are an update strobe, color, number, clear, and outputs score, count and full.
- score_judge itself contains the FSM, the capture registers, the judging logic and the drop flag.

## Test plan
- Reset, then deal whose=0, color=2, number=4 → after edge N+1: score0 = 5, count0 = 1, winner = 00; busy high for exactly one cycle.
- Player0 receives three consecutive color=1 cards with number=0 → score0 = 1, 2, then 6 (bonus applied); player1's streak is unaffected.
- Player1 is brought to score 18, then dealt number=2 (+3) → score1 = 21, winner = 10, game_over = 1; a following deal sets drop and the scores do not change.
- Player0 at score 19 is dealt number=4 → score0 = 24, winner = 10 (bust).
- Invalid card color=0, then number=6 → both dropped, drop = 1, counts unchanged. Then restart together with a valid deal → all outputs cleared and the deal is discarded.
- Both hands filled with 8 number=0 cards of alternating colors, 8 each → winner = 11 when equal, or the higher player when unequal. A ninth deal to a full hand sets drop. Reset asserted during EVAL clears everything immediately.
